// File: rtl/gf_reduce_seq_if.sv
// gf_reduce_seq_if: operand/result handshake bundle for gf_reduce_seq.
//   in_valid/in_ready/in_data   : unreduced 2W-bit operand (producer -> reducer)
//   out_valid/out_ready/out_data: reduced W-bit result (reducer -> consumer)
//   busy                        : reducer is not idle
// master = producer/consumer side, slave = reducer side.
interface gf_reduce_seq_if #(
    parameter int unsigned W = 128
);
    logic             in_valid;
    logic             in_ready;
    logic [2*W-1:0]   in_data;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     out_data;
    logic             busy;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, busy
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, busy
    );
endinterface

// File: rtl/gf_reduce_seq.sv
// gf_reduce_seq: sequential reduction of a 2W-bit GF(2) polynomial modulo
// m(x) = x^W + POLY, retiring STEP high-order coefficients per clock.
// Ports:
//   clk    : clock, rising edge
//   rst_n  : synchronous active-low reset
//   poly_i : runtime low W bits of the modulus (only with GF_REDUCE_RUNTIME_POLY_EN)
//   bus    : gf_reduce_seq_if.slave (operand in, result out, busy)
// Optional feature macro: GF_REDUCE_RUNTIME_POLY_EN (modulus sampled per operation).
module gf_reduce_seq #(
    parameter int unsigned  W    = 128,
    parameter logic [W-1:0] POLY = 'h87,
    parameter int unsigned  STEP = 8
) (
    input  logic            clk,
    input  logic            rst_n,
`ifdef GF_REDUCE_RUNTIME_POLY_EN
    input  logic [W-1:0]    poly_i,
`endif
    gf_reduce_seq_if.slave  bus
);

    localparam int unsigned STEP_SAFE = (STEP == 0) ? 1 : STEP;
    localparam int unsigned NSTEPS    = W / STEP_SAFE;
    localparam int unsigned CNT_W     = (NSTEPS > 1) ? $clog2(NSTEPS) : 1;
    localparam int unsigned ACC_W     = 2 * W;
    localparam int unsigned IDX_W     = $clog2(ACC_W);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NSTEPS - 1);

    // Reject step sizes that do not tile the high half exactly.
    if (STEP < 1 || STEP > W || (W % STEP_SAFE) != 0) begin : g_bad_step
        $error("gf_reduce_seq: STEP must be in 1..W and divide W");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic               busy_q, busy_d;
    logic [W-1:0]       poly_cur;
    logic [ACC_W-1:0]   modulus;
    logic [ACC_W-1:0]   acc_red;

`ifdef GF_REDUCE_RUNTIME_POLY_EN
    logic [W-1:0]       poly_q, poly_d;
    assign poly_cur = poly_q;
`else
    assign poly_cur = POLY;
`endif

    // Full modulus with the implicit x^W term made explicit.
    assign modulus = {{(W-1){1'b0}}, 1'b1, poly_cur};

    // One cycle of long division: STEP bit steps chained high to low so each
    // step sees the XORs of the steps above it.
    always_comb begin
        acc_red = acc_q;
        for (int k = 0; k < int'(STEP_SAFE); k++) begin
            int j;
            j = int'(ACC_W) - 1 - int'(cnt_q) * int'(STEP_SAFE) - k;
            if (acc_red[IDX_W'(j)]) begin
                acc_red = acc_red ^ (modulus << (j - int'(W)));
            end
        end
    end

    // Next-state and registered-output decode.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        in_ready_d  = 1'b0;
        out_valid_d = 1'b0;
        busy_d      = 1'b1;
`ifdef GF_REDUCE_RUNTIME_POLY_EN
        poly_d      = poly_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    acc_d   = bus.in_data;
                    cnt_d   = '0;
                    state_d = RUN;
`ifdef GF_REDUCE_RUNTIME_POLY_EN
                    poly_d  = poly_i;
`endif
                end
            end
            RUN: begin
                acc_d = acc_red;
                if (cnt_q == LAST_CNT) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
        busy_d      = (state_d != IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            acc_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef GF_REDUCE_RUNTIME_POLY_EN
            poly_q      <= POLY;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
`ifdef GF_REDUCE_RUNTIME_POLY_EN
            poly_q      <= poly_d;
`endif
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = acc_q[W-1:0];
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_gf_reduce_seq.sv
// tb_gf_reduce_seq: directed and model-checked bench for gf_reduce_seq.
// One W=8/STEP=1 instance plus W=128 instances at STEP 1, 8, 32 and 128.
module tb_gf_reduce_seq;

    logic clk;
    logic rst_n;
    int   nvec;
    int   nfail;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int step_of(input int g);
        case (g)
            0:       return 1;
            1:       return 8;
            2:       return 32;
            default: return 128;
        endcase
    endfunction

    // Horner-style remainder: shift in one coefficient at a time, fold x^w.
    function automatic logic [127:0] ref_mod(input logic [255:0] a, input int w,
                                             input logic [127:0] poly);
        logic [127:0] r;
        logic [127:0] mask;
        logic         carry;
        r    = '0;
        mask = (w == 128) ? '1 : ((128'(1) << w) - 128'(1));
        for (int i = 2 * w - 1; i >= 0; i--) begin
            carry = r[w-1];
            r     = ((r << 1) | 128'(a[i])) & mask;
            if (carry) r = r ^ poly;
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- W=8, POLY=0x1B, STEP=1 instance ----------------
    gf_reduce_seq_if #(.W(8)) bus8 ();
    logic        vin8;
    logic        rdy8;
    logic [15:0] din8;
    assign bus8.in_valid  = vin8;
    assign bus8.in_data   = din8;
    assign bus8.out_ready = rdy8;
`ifdef GF_REDUCE_RUNTIME_POLY_EN
    logic [7:0]  poly8;
`endif

    gf_reduce_seq #(.W(8), .POLY(8'h1B), .STEP(1)) u_dut8 (
        .clk    (clk),
        .rst_n  (rst_n),
`ifdef GF_REDUCE_RUNTIME_POLY_EN
        .poly_i (poly8),
`endif
        .bus    (bus8)
    );

    // ---------------- W=128, POLY=0x87 instances ----------------
    logic         vin  [4];
    logic         rdy  [4];
    logic [255:0] din  [4];
    logic         ovld [4];
    logic         irdy [4];
    logic         obsy [4];
    logic [127:0] odat [4];

    for (genvar g = 0; g < 4; g++) begin : g_w128
        localparam int unsigned S = step_of(g);
        gf_reduce_seq_if #(.W(128)) bus ();
        assign bus.in_valid  = vin[g];
        assign bus.in_data   = din[g];
        assign bus.out_ready = rdy[g];
        assign ovld[g]       = bus.out_valid;
        assign irdy[g]       = bus.in_ready;
        assign obsy[g]       = bus.busy;
        assign odat[g]       = bus.out_data;

        gf_reduce_seq #(.W(128), .POLY(128'h87), .STEP(S)) u_dut (
            .clk    (clk),
            .rst_n  (rst_n),
`ifdef GF_REDUCE_RUNTIME_POLY_EN
            .poly_i (128'h87),
`endif
            .bus    (bus)
        );
    end

    // Apply one operand to the W=8 instance; leaves the result held in DONE.
    task automatic run8(input logic [15:0] d, input logic [7:0] e, input string tag);
        int cyc;
`ifdef GF_REDUCE_RUNTIME_POLY_EN
        logic [7:0] p_save;
        p_save = poly8;
`endif
        @(negedge clk);
        chk({tag, "/in_ready"}, 256'(bus8.in_ready), 256'(1));
        din8 = d;
        vin8 = 1'b1;
        @(posedge clk); #1;
        vin8 = 1'b0;
        din8 = 16'hFFFF;
`ifdef GF_REDUCE_RUNTIME_POLY_EN
        poly8 = ~p_save;
`endif
        chk({tag, "/busy"}, 256'(bus8.busy), 256'(1));
        cyc = 0;
        while (bus8.out_valid !== 1'b1 && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk({tag, "/latency"}, 256'(cyc), 256'(8));
        chk({tag, "/data"}, 256'(bus8.out_data), 256'(e));
`ifdef GF_REDUCE_RUNTIME_POLY_EN
        poly8 = p_save;
`endif
    endtask

    task automatic release8(input string tag);
        rdy8 = 1'b1;
        @(posedge clk); #1;
        rdy8 = 1'b0;
        chk({tag, "/rel_in_ready"}, 256'(bus8.in_ready), 256'(1));
        chk({tag, "/rel_out_valid"}, 256'(bus8.out_valid), 256'(0));
    endtask

    // Apply one operand to W=128 instance g, check result and latency, consume.
    task automatic run128(input int g, input logic [255:0] d, input logic [127:0] e,
                          input string tag);
        int cyc;
        @(negedge clk);
        chk({tag, "/in_ready"}, 256'(irdy[g]), 256'(1));
        din[g] = d;
        vin[g] = 1'b1;
        @(posedge clk); #1;
        vin[g] = 1'b0;
        din[g] = '1;
        chk({tag, "/busy"}, 256'(obsy[g]), 256'(1));
        cyc = 0;
        while (ovld[g] !== 1'b1 && cyc < 300) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk({tag, "/latency"}, 256'(cyc), 256'(128 / step_of(g)));
        chk({tag, "/data"}, 256'(odat[g]), 256'(e));
        rdy[g] = 1'b1;
        @(posedge clk); #1;
        rdy[g] = 1'b0;
        chk({tag, "/rel_in_ready"}, 256'(irdy[g]), 256'(1));
    endtask

    function automatic logic [255:0] rand256();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int           hits;
        logic [255:0] d;
        nvec  = 0;
        nfail = 0;
        rst_n = 1'b0;
        vin8  = 1'b0;
        rdy8  = 1'b0;
        din8  = '0;
`ifdef GF_REDUCE_RUNTIME_POLY_EN
        poly8 = 8'h1B;
`endif
        for (int i = 0; i < 4; i++) begin
            vin[i] = 1'b0;
            rdy[i] = 1'b0;
            din[i] = '0;
        end

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst/in_ready8", 256'(bus8.in_ready), 256'(1));
        chk("rst/out_valid8", 256'(bus8.out_valid), 256'(0));
        chk("rst/busy8", 256'(bus8.busy), 256'(0));
        chk("rst/in_ready128", 256'(irdy[1]), 256'(1));
        chk("rst/busy128", 256'(obsy[1]), 256'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // W=8 directed vectors
        run8(16'h2B79, 8'hC1, "w8_2b79");
        // Backpressure: result held with out_ready low
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp/out_valid", 256'(bus8.out_valid), 256'(1));
            chk("bp/out_data", 256'(bus8.out_data), 256'(8'hC1));
            chk("bp/in_ready", 256'(bus8.in_ready), 256'(0));
        end
        release8("bp");
        chk("bp/busy_idle", 256'(bus8.busy), 256'(0));
        run8(16'h0100, 8'h1B, "w8_x8");
        release8("w8_x8");
        run8(16'h00FF, 8'hFF, "w8_low");
        release8("w8_low");
        run8(16'h0000, 8'h00, "w8_zero");
        release8("w8_zero");

        // W=128 STEP=8 directed vectors
        run128(1, 256'(1) << 128, 128'h87, "s8_x128");
        run128(1, 256'h1234, 128'h1234, "s8_lowonly");
        run128(1, 256'(1) << 255, ref_mod(256'(1) << 255, 128, 128'h87), "s8_top");

        // Reset during RUN cycle 3 abandons the operation
        @(negedge clk);
        din[1] = 256'(1) << 200;
        vin[1] = 1'b1;
        @(posedge clk); #1;
        vin[1] = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("midrst/in_ready", 256'(irdy[1]), 256'(1));
        chk("midrst/out_valid", 256'(ovld[1]), 256'(0));
        chk("midrst/busy", 256'(obsy[1]), 256'(0));
        @(negedge clk);
        rst_n = 1'b1;
        hits = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (ovld[1] === 1'b1) hits++;
        end
        chk("midrst/no_valid", 256'(hits), 256'(0));
        d = rand256();
        run128(1, d, ref_mod(d, 128, 128'h87), "midrst/next");

        // Random operands across step sizes
        for (int g = 0; g < 4; g++) begin
            for (int n = 0; n < 3; n++) begin
                d = rand256();
                run128(g, d, ref_mod(d, 128, 128'h87), $sformatf("rand_s%0d_%0d", step_of(g), n));
            end
        end

`ifdef GF_REDUCE_RUNTIME_POLY_EN
        // Runtime modulus: sampled at acceptance, later changes ignored
        poly8 = 8'h1D;
        run8(16'h0100, 8'h1D, "rp_1d");
        release8("rp_1d");
        poly8 = 8'h1B;
        run8(16'h2B79, 8'hC1, "rp_1b");
        release8("rp_1b");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule

// File: doc/gf_reduce_seq.md
GF_REDUCE_SEQ -- requirements
Module: gf_reduce_seq

Interface
REQ-001 Parameter W, default 128, SHALL be the field degree and the output width.
REQ-002 Parameter POLY, default 'h87, SHALL be the low W bits of the modulus m(x) = x^W + POLY; the x^W term is implicit.
REQ-003 Parameter STEP, default 8, SHALL be the number of high-order bits reduced per clock cycle.
REQ-004 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  SHALL be the synchronous, active-low reset.
REQ-006 in_valid  input  1  SHALL indicate that in_data holds an operand.
REQ-007 in_ready  output  1  SHALL indicate that the block can accept an operand.
REQ-008 in_data  input  2W  SHALL be the unreduced polynomial, bit k = coefficient of x^k.
REQ-009 out_valid  output  1  SHALL indicate that out_data holds a result.
REQ-010 out_ready  input  1  SHALL indicate that the consumer accepts the result.
REQ-011 out_data  output  W  SHALL be the reduced result, in_data mod m(x).
REQ-012 busy  output  1  SHALL be high in every state other than IDLE.

Function
REQ-013 The block SHALL have exactly three states: IDLE, RUN and DONE, with IDLE as the reset state.
REQ-014 in_ready SHALL be high only in IDLE; a transfer occurs when in_valid and in_ready are both high at a rising edge.
REQ-015 On a transfer, in_data SHALL be captured into a 2W-bit accumulator, the step counter SHALL be cleared, and the state SHALL become RUN.
REQ-016 In RUN, each cycle SHALL process accumulator bits j = 2W-1-c*STEP down to j = 2W-STEP-c*STEP in descending order: if bit j is 1, the accumulator is XORed with m(x) shifted left by j-W.
REQ-017 The result of each bit step SHALL feed the next lower bit step within the same cycle, so carries from POLY into lower high-half bits are honoured.
REQ-018 After W/STEP RUN cycles, the state SHALL become DONE and out_data SHALL equal accumulator bits W-1:0.
REQ-019 Latency: out_valid SHALL rise exactly W/STEP cycles after the accepting edge, independent of the operand value, including when the high half is all zero.
REQ-020 In DONE, out_valid and out_data SHALL hold stable until out_ready is high at an edge; the state then becomes IDLE.
REQ-021 in_ready SHALL be low in DONE, so no new operand is accepted in the cycle the result is consumed.
REQ-022 out_valid SHALL be low in IDLE and RUN; out_data SHALL be don't-care outside DONE.
REQ-023 in_data and in_valid SHALL be ignored outside IDLE.
REQ-024 The step counter SHALL be ceil(log2(W/STEP)) bits wide, minimum 1 bit, and SHALL not wrap within an operation.
REQ-025 Elaboration SHALL fail if STEP < 1, STEP > W, or W is not a multiple of STEP.

Reset
REQ-026 While rst_n is low at an edge, the state SHALL become IDLE, with out_valid = 0, in_ready = 1 from the next cycle, busy = 0, and the counter and accumulator cleared.
REQ-027 A reset asserted during RUN or DONE SHALL abandon the operation, and no out_valid SHALL follow.

Configuration
REQ-028 With GF_REDUCE_RUNTIME_POLY_EN defined, an input port poly_i [W-1:0] SHALL exist; it is sampled on the accepting edge and used as the low W bits of the modulus for that operation.
REQ-029 Without GF_REDUCE_RUNTIME_POLY_EN, poly_i SHALL NOT exist and the parameter POLY SHALL be used for every operation.

Verification
REQ-030 W=8, POLY='h1B, STEP=1: in_data='h2B79 -> out_data='hC1, with out_valid exactly 8 cycles after acceptance.
REQ-031 W=128, POLY='h87, STEP=8: in_data=1<<128 -> out_data='h87 after 16 cycles; in_data='h1234 (high half zero) -> out_data='h1234 after 16 cycles.
REQ-032 Backpressure: hold out_ready low for 5 cycles in DONE -> out_valid and out_data stable, in_ready low; out_ready high -> IDLE next cycle, in_ready high.
REQ-033 Reset mid-RUN: rst_n low during RUN cycle 3 -> IDLE next cycle, no out_valid; the next operand reduces correctly.
REQ-034 Random operands for STEP in {1,8,32,128} at W=128 -> out_data matches a bitwise long-division model, with latency W/STEP.
REQ-035 With GF_REDUCE_RUNTIME_POLY_EN defined: W=8, poly_i='h1B, in_data='h2B79 -> 'hC1; poly_i changed during RUN -> result unaffected.
